// File: rtl/reaction_duel_sched.sv
`default_nettype none
// ============================================================================
// Module   : reaction_duel_sched
// Purpose  : Two-player session scheduler for the reaction-timer core. The
//            single core is shared between the players in strict
//            alternation. Each player gets 2**ROUNDS_LOG2 trials. When the
//            session ends, the block publishes per-player best and average
//            times and declares a winner.
// Ports    : clk_i            system clock
//            areset_n_i       asynchronous active-low reset
//            req_i[1:0]       player buttons (level, debounced), bit p = player p
//            abort_i          synchronous session abort
//            core_start_o     one-cycle pulse, timer core begins a trial
//            core_done_i      one-cycle pulse, trial finished
//            core_result_i    reaction value (10000 = timeout)
//            core_early_i     false start qualifier for core_done_i
//            grant_o          one-hot core owner, 00 when none
//            session_active_o high from session start until results are final
//            round_idx_o      trials completed this session
//            best0_o/best1_o  minimum recorded value per player
//            avg0_o/avg1_o    per-player sum >> ROUNDS_LOG2
//            winner_o         01 p0, 10 p1, 11 tie, 00 undecided
//            done_o           results final
// Revision : 1.0  initial release
// ============================================================================
module reaction_duel_sched #(
  parameter int unsigned ROUNDS_LOG2 = 2,
  parameter int unsigned PENALTY     = 9999
) (
  input  logic        clk_i,
  input  logic        areset_n_i,
  input  logic [1:0]  req_i,
  input  logic        abort_i,
  output logic        core_start_o,
  input  logic        core_done_i,
  input  logic [13:0] core_result_i,
  input  logic        core_early_i,
  output logic [1:0]  grant_o,
  output logic        session_active_o,
  output logic [3:0]  round_idx_o,
  output logic [13:0] best0_o,
  output logic [13:0] best1_o,
  output logic [13:0] avg0_o,
  output logic [13:0] avg1_o,
  output logic [1:0]  winner_o,
  output logic        done_o
);

  localparam int unsigned ROUNDS    = 1 << ROUNDS_LOG2;
  // The trial counter is one bit wider than the round_idx port so that the
  // final count of 16 (ROUNDS_LOG2 = 3) is still recognised internally.
  localparam logic [4:0]  TOTAL     = 5'(2 * ROUNDS);
  localparam logic [13:0] PEN       = 14'(PENALTY);
  localparam logic [13:0] BEST_INIT = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_WAIT   = 3'd2,
    S_RECORD = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        turn_q, turn_d;
  logic [1:0]  req_q;
  logic [16:0] sum0_q, sum0_d, sum1_q, sum1_d;
  logic [13:0] best0_q, best0_d, best1_q, best1_d;
  logic [13:0] avg0_q, avg0_d, avg1_q, avg1_d;
  logic [1:0]  winner_q, winner_d;
  logic        done_q, done_d;
  logic [4:0]  round_q, round_d;
  logic        core_start_q, core_start_d;
  logic [1:0]  grant_q, grant_d;
  logic        active_q, active_d;

  logic [1:0]  rise;
  logic [13:0] trial_val;
  logic [13:0] avg0_n, avg1_n;
  logic [1:0]  winner_n;

  assign rise      = req_i & ~req_q;
  assign trial_val = core_early_i ? PEN : core_result_i;

  // Averages and winner as they will be published on entry to FINISH;
  // sums and bests already include the last trial by the RECORD cycle.
  assign avg0_n = 14'(sum0_q >> ROUNDS_LOG2);
  assign avg1_n = 14'(sum1_q >> ROUNDS_LOG2);

  always_comb begin
    if (avg0_n < avg1_n) begin
      winner_n = 2'b01;
    end else if (avg1_n < avg0_n) begin
      winner_n = 2'b10;
    end else if (best0_q < best1_q) begin
      winner_n = 2'b01;
    end else if (best1_q < best0_q) begin
      winner_n = 2'b10;
    end else begin
      winner_n = 2'b11;
    end
  end

  // req_q resets to all-ones so a button held through reset never looks
  // like a fresh press.
  always_ff @(posedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state_q      <= S_IDLE;
      turn_q       <= 1'b0;
      req_q        <= 2'b11;
      sum0_q       <= '0;
      sum1_q       <= '0;
      best0_q      <= BEST_INIT;
      best1_q      <= BEST_INIT;
      avg0_q       <= '0;
      avg1_q       <= '0;
      winner_q     <= 2'b00;
      done_q       <= 1'b0;
      round_q      <= '0;
      core_start_q <= 1'b0;
      grant_q      <= 2'b00;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      turn_q       <= turn_d;
      req_q        <= req_i;
      sum0_q       <= sum0_d;
      sum1_q       <= sum1_d;
      best0_q      <= best0_d;
      best1_q      <= best1_d;
      avg0_q       <= avg0_d;
      avg1_q       <= avg1_d;
      winner_q     <= winner_d;
      done_q       <= done_d;
      round_q      <= round_d;
      core_start_q <= core_start_d;
      grant_q      <= grant_d;
      active_q     <= active_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    turn_d       = turn_q;
    sum0_d       = sum0_q;
    sum1_d       = sum1_q;
    best0_d      = best0_q;
    best1_d      = best1_q;
    avg0_d       = avg0_q;
    avg1_d       = avg1_q;
    winner_d     = winner_q;
    done_d       = done_q;
    round_d      = round_q;
    core_start_d = 1'b0;
    grant_d      = grant_q;
    active_d     = active_q;

    case (state_q)
      // A press in IDLE or FINISH opens a new session; it never doubles as
      // player 0's trial start.
      S_IDLE, S_FINISH: begin
        if (|rise) begin
          state_d  = S_ARB;
          sum0_d   = '0;
          sum1_d   = '0;
          best0_d  = BEST_INIT;
          best1_d  = BEST_INIT;
          avg0_d   = '0;
          avg1_d   = '0;
          round_d  = '0;
          winner_d = 2'b00;
          done_d   = 1'b0;
          turn_d   = 1'b0;
          active_d = 1'b1;
          grant_d  = 2'b01;
        end
      end
      S_ARB: begin
        if (rise[turn_q]) begin
          core_start_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_done_i) begin
          if (!turn_q) begin
            sum0_d = sum0_q + 17'(trial_val);
            if (trial_val < best0_q) begin
              best0_d = trial_val;
            end
          end else begin
            sum1_d = sum1_q + 17'(trial_val);
            if (trial_val < best1_q) begin
              best1_d = trial_val;
            end
          end
          round_d = round_q + 5'd1;
          state_d = S_RECORD;
        end
      end
      S_RECORD: begin
        if (round_q == TOTAL) begin
          state_d  = S_FINISH;
          avg0_d   = avg0_n;
          avg1_d   = avg1_n;
          winner_d = winner_n;
          done_d   = 1'b1;
          active_d = 1'b0;
          grant_d  = 2'b00;
        end else begin
          turn_d  = ~turn_q;
          grant_d = turn_q ? 2'b01 : 2'b10;
          state_d = S_ARB;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort outranks every other event in the same cycle.
    if (abort_i) begin
      state_d      = S_IDLE;
      turn_d       = 1'b0;
      sum0_d       = '0;
      sum1_d       = '0;
      best0_d      = BEST_INIT;
      best1_d      = BEST_INIT;
      avg0_d       = '0;
      avg1_d       = '0;
      winner_d     = 2'b00;
      done_d       = 1'b0;
      round_d      = '0;
      core_start_d = 1'b0;
      grant_d      = 2'b00;
      active_d     = 1'b0;
    end
  end

  assign core_start_o     = core_start_q;
  assign grant_o          = grant_q;
  assign session_active_o = active_q;
  assign round_idx_o      = round_q[3:0];
  assign best0_o          = best0_q;
  assign best1_o          = best1_q;
  assign avg0_o           = avg0_q;
  assign avg1_o           = avg1_q;
  assign winner_o         = winner_q;
  assign done_o           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_duel_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_reaction_duel_sched
// Purpose  : Self-checking bench for reaction_duel_sched. Two instances are
//            used: dut0 with ROUNDS_LOG2=1 and dut1 with ROUNDS_LOG2=2. Only
//            the selected instance sees button and core traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_reaction_duel_sched;

  typedef struct packed {
    logic            d;
    logic [3:0]      n;
    logic [7:0][13:0] r0;
    logic [7:0][13:0] r1;
    logic [7:0]      e0;
    logic [13:0]     best0;
    logic [13:0]     best1;
    logic [13:0]     avg0;
    logic [13:0]     avg1;
    logic [1:0]      winner;
    logic [3:0]      ridx;
  } sess_t;

  typedef struct packed {
    logic [13:0] best0;
    logic [13:0] best1;
    logic [13:0] avg0;
    logic [13:0] avg1;
    logic [1:0]  winner;
    logic [3:0]  ridx;
  } exp_t;

  logic        clk = 1'b0;
  logic        areset_n;
  logic [1:0]  req;
  logic        abort;
  logic        core_done;
  logic [13:0] core_result;
  logic        core_early;
  logic        sel;

  logic [1:0]  req_v        [2];
  logic        done_in_v    [2];
  logic        core_start_w [2];
  logic [1:0]  grant_w      [2];
  logic        active_w     [2];
  logic [3:0]  ridx_w       [2];
  logic [13:0] best0_w      [2];
  logic [13:0] best1_w      [2];
  logic [13:0] avg0_w       [2];
  logic [13:0] avg1_w       [2];
  logic [1:0]  winner_w     [2];
  logic        done_w       [2];
  logic        done_prev    [2];

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  sess_t tbl [6];

  always #5 clk = ~clk;

  assign req_v[0]     = (sel == 1'b0) ? req : 2'b00;
  assign req_v[1]     = (sel == 1'b1) ? req : 2'b00;
  assign done_in_v[0] = (sel == 1'b0) ? core_done : 1'b0;
  assign done_in_v[1] = (sel == 1'b1) ? core_done : 1'b0;

  reaction_duel_sched #(.ROUNDS_LOG2(1), .PENALTY(9999)) u_dut0 (
    .clk_i(clk), .areset_n_i(areset_n), .req_i(req_v[0]), .abort_i(abort),
    .core_start_o(core_start_w[0]), .core_done_i(done_in_v[0]),
    .core_result_i(core_result), .core_early_i(core_early),
    .grant_o(grant_w[0]), .session_active_o(active_w[0]),
    .round_idx_o(ridx_w[0]), .best0_o(best0_w[0]), .best1_o(best1_w[0]),
    .avg0_o(avg0_w[0]), .avg1_o(avg1_w[0]), .winner_o(winner_w[0]),
    .done_o(done_w[0])
  );

  reaction_duel_sched #(.ROUNDS_LOG2(2), .PENALTY(9999)) u_dut1 (
    .clk_i(clk), .areset_n_i(areset_n), .req_i(req_v[1]), .abort_i(abort),
    .core_start_o(core_start_w[1]), .core_done_i(done_in_v[1]),
    .core_result_i(core_result), .core_early_i(core_early),
    .grant_o(grant_w[1]), .session_active_o(active_w[1]),
    .round_idx_o(ridx_w[1]), .best0_o(best0_w[1]), .best1_o(best1_w[1]),
    .avg0_o(avg0_w[1]), .avg1_o(avg1_w[1]), .winner_o(winner_w[1]),
    .done_o(done_w[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sb0.size() : sb1.size();
  endfunction

  // Scoreboard consumer: each rising done pops one expected result.
  task automatic sb_pop(input int d);
    exp_t e;
    if (qsize(d) == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_done dut%0d: got done=1 expected no pending result", d);
    end else begin
      e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
      chk($sformatf("dut%0d best0", d), 32'(best0_w[d]), 32'(e.best0));
      chk($sformatf("dut%0d best1", d), 32'(best1_w[d]), 32'(e.best1));
      chk($sformatf("dut%0d avg0", d), 32'(avg0_w[d]), 32'(e.avg0));
      chk($sformatf("dut%0d avg1", d), 32'(avg1_w[d]), 32'(e.avg1));
      chk($sformatf("dut%0d winner", d), 32'(winner_w[d]), 32'(e.winner));
      chk($sformatf("dut%0d round_idx_final", d), 32'(ridx_w[d]), 32'(e.ridx));
      chk($sformatf("dut%0d active_final", d), 32'(active_w[d]), 32'd0);
      chk($sformatf("dut%0d grant_final", d), 32'(grant_w[d]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_w[d] === 1'b1 && done_prev[d] !== 1'b1) sb_pop(d);
      done_prev[d] <= done_w[d];
    end
  end

  task automatic start_session(input int d);
    req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    chk("start active", 32'(active_w[d]), 32'd1);
    chk("start grant", 32'(grant_w[d]), 32'd1);
    chk("start round_idx", 32'(ridx_w[d]), 32'd0);
    chk("start done", 32'(done_w[d]), 32'd0);
    chk("start best0", 32'(best0_w[d]), 32'h3FFF);
    chk("start avg1", 32'(avg1_w[d]), 32'd0);
    chk("start winner", 32'(winner_w[d]), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic press_start(input int d, input int p);
    req[p] = 1'b1;
    @(posedge clk); #1;
    req[p] = 1'b0;
    chk("core_start latency", 32'(core_start_w[d]), 32'd1);
    chk("trial grant", 32'(grant_w[d]), 32'(1 << p));
    @(posedge clk); #1;
    chk("core_start width", 32'(core_start_w[d]), 32'd0);
  endtask

  task automatic trial(input int d, input int p, input logic [13:0] res, input logic e);
    press_start(d, p);
    repeat (2) @(posedge clk);
    #1;
    core_done   = 1'b1;
    core_result = res;
    core_early  = e;
    @(posedge clk); #1;
    core_done   = 1'b0;
    core_result = '0;
    core_early  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_session(input sess_t s);
    exp_t e;
    sel = s.d;
    start_session(int'(s.d));
    e.best0 = s.best0; e.best1 = s.best1; e.avg0 = s.avg0; e.avg1 = s.avg1;
    e.winner = s.winner; e.ridx = s.ridx;
    if (s.d == 1'b0) sb0.push_back(e); else sb1.push_back(e);
    for (int i = 0; i < 2 * int'(s.n); i++) begin
      int k;
      k = i / 2;
      if (i % 2 == 0) trial(int'(s.d), 0, s.r0[k], s.e0[k]);
      else            trial(int'(s.d), 1, s.r1[k], 1'b0);
      chk("round_idx step", 32'(ridx_w[s.d]), 32'(i + 1));
    end
    for (int c = 0; c < 10 && qsize(int'(s.d)) != 0; c++) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(qsize(int'(s.d))), 32'd0);
  endtask

  function automatic sess_t mk(input logic d, input int n,
                               input int a0, input int a1, input int b0, input int b1,
                               input logic ea, input int xb0, input int xb1,
                               input int xa0, input int xa1, input logic [1:0] w,
                               input int ri);
    sess_t s;
    s = '0;
    s.d = d; s.n = 4'(n);
    s.r0[0] = 14'(a0); s.r0[1] = 14'(a1);
    s.r1[0] = 14'(b0); s.r1[1] = 14'(b1);
    s.e0[0] = ea;
    s.best0 = 14'(xb0); s.best1 = 14'(xb1);
    s.avg0 = 14'(xa0); s.avg1 = 14'(xa1);
    s.winner = w; s.ridx = 4'(ri);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n = 1'b0; req = 2'b11; abort = 1'b0; sel = 1'b0;
    core_done = 1'b0; core_result = '0; core_early = 1'b0;

    // Expected results table, ROUNDS_LOG2=1 on dut0 and ROUNDS_LOG2=2 on dut1.
    tbl[0] = mk(1'b0, 2, 200, 300, 250, 150, 1'b0, 200, 150, 250, 200, 2'b10, 4);
    tbl[1] = mk(1'b0, 2,  37, 100, 500, 500, 1'b1, 100, 500, 5049, 500, 2'b10, 4);
    tbl[2] = mk(1'b0, 2, 300, 100, 200, 200, 1'b0, 100, 200, 200, 200, 2'b01, 4);
    tbl[3] = mk(1'b0, 2, 200, 200, 200, 200, 1'b0, 200, 200, 200, 200, 2'b11, 4);
    tbl[4] = mk(1'b0, 2, 120, 130, 400, 401, 1'b0, 120, 400, 125, 400, 2'b01, 4);
    tbl[5] = mk(1'b1, 4, 10000, 10000, 10000, 10000, 1'b0, 10000, 10000, 10000, 10000, 2'b11, 8);
    for (int k = 2; k < 4; k++) begin
      tbl[5].r0[k] = 14'd10000;
      tbl[5].r1[k] = 14'd10000;
    end

    // Reset values while reset is held, buttons held down.
    #22;
    for (int d = 0; d < 2; d++) begin
      chk("rst core_start", 32'(core_start_w[d]), 32'd0);
      chk("rst grant", 32'(grant_w[d]), 32'd0);
      chk("rst active", 32'(active_w[d]), 32'd0);
      chk("rst round_idx", 32'(ridx_w[d]), 32'd0);
      chk("rst best0", 32'(best0_w[d]), 32'h3FFF);
      chk("rst best1", 32'(best1_w[d]), 32'h3FFF);
      chk("rst avg0", 32'(avg0_w[d]), 32'd0);
      chk("rst winner", 32'(winner_w[d]), 32'd0);
      chk("rst done", 32'(done_w[d]), 32'd0);
    end
    @(negedge clk);
    areset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("held button no start", 32'(active_w[0]), 32'd0);
    req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("release no start", 32'(active_w[0]), 32'd0);

    for (int i = 0; i < 6; i++) run_session(tbl[i]);

    // Non-granted player pressing in ARB is ignored.
    sel = 1'b0;
    start_session(0);
    req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("ignore p1 start", 32'(core_start_w[0]), 32'd0);
    chk("ignore p1 grant", 32'(grant_w[0]), 32'd1);
    @(posedge clk); #1;
    chk("ignore p1 start2", 32'(core_start_w[0]), 32'd0);
    press_start(0, 0);

    // Abort and core_done together in WAIT: abort wins.
    abort = 1'b1; core_done = 1'b1; core_result = 14'd55;
    @(posedge clk); #1;
    abort = 1'b0; core_done = 1'b0; core_result = '0;
    chk("abort active", 32'(active_w[0]), 32'd0);
    chk("abort grant", 32'(grant_w[0]), 32'd0);
    chk("abort round_idx", 32'(ridx_w[0]), 32'd0);
    chk("abort best0", 32'(best0_w[0]), 32'h3FFF);
    chk("abort done", 32'(done_w[0]), 32'd0);
    @(posedge clk); #1;
    chk("abort round_idx later", 32'(ridx_w[0]), 32'd0);

    // Asynchronous reset mid-trial; the late core_done must be ignored.
    start_session(0);
    press_start(0, 0);
    #3;
    areset_n = 1'b0;
    #1;
    chk("async rst grant", 32'(grant_w[0]), 32'd0);
    chk("async rst active", 32'(active_w[0]), 32'd0);
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b1; core_result = 14'd77;
    @(posedge clk); #1;
    core_done = 1'b0; core_result = '0;
    @(posedge clk); #1;
    chk("stale done round_idx", 32'(ridx_w[0]), 32'd0);
    chk("stale done best0", 32'(best0_w[0]), 32'h3FFF);
    chk("stale done active", 32'(active_w[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
